mc_main_ctrl: RTL and testbench

- Multi-cycle main control unit for the MIPS datapath.
- Decodes the instruction opcode through a registered finite-state machine and drives all datapath enables and mux selects.
- Drives the 2-bit `ALU_OP` consumed by the ALU control decoder, which pairs it with `funct` to select the ALU operation. This block is the producer side of that `ALU_OP` interface.
- Also produces the gated PC enable, a one-cycle retire pulse and an illegal-opcode flag.

---
 rtl/mc_main_ctrl.sv | 128 ++++++++++++
 tb/tb_mc_main_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control unit.
// A registered FSM walks each instruction through its phases. All datapath
// controls are registered alongside the state, so they are a clean Moore
// decode of STATE. Only PC_EN (gated by zero) and ILLEGAL (opcode check in
// DECODE) are combinational.
module mc_main_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PC_WRITE,
    output logic       PC_WRITE_COND,
    output logic       IorD,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       MEM_TO_REG,
    output logic       REG_DST,
    output logic       REG_WRITE,
    output logic       ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] PC_SOURCE,
    output logic [1:0] ALU_OP,
    output logic       PC_EN,
    output logic       RETIRE,
    output logic       ILLEGAL,
    output logic [3:0] STATE
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_RST    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t      state_reg;
    logic [16:0] ctrl_reg;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Opcode is only consulted in DECODE and MADDR; unused codes recover to FETCH.
    function automatic state_t next_state(input state_t s, input logic [5:0] op);
        case (s)
            S_RST:    return S_FETCH;
            S_FETCH:  return S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE: return S_EXEC;
                    OP_LW:    return S_MADDR;
                    OP_SW:    return S_MADDR;
                    OP_BEQ:   return S_BRANCH;
                    OP_J:     return S_JUMP;
                    OP_ADDI:  return S_IEXEC;
                    default:  return S_FETCH;
                endcase
            end
            S_MADDR:  return (op == OP_LW) ? S_MRD : S_MWR;
            S_MRD:    return S_MWB;
            S_EXEC:   return S_RWB;
            S_IEXEC:  return S_IWB;
            default:  return S_FETCH;
        endcase
    endfunction

    // Control vector for a state, packed in output-port order.
    function automatic logic [16:0] decode_ctrl(input state_t s);
        logic       pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ret;
        logic [1:0] asb, pcs, aop;
        pw = 1'b0; pwc = 1'b0; iord = 1'b0; mr = 1'b0; mw = 1'b0; irw = 1'b0;
        m2r = 1'b0; rd = 1'b0; rw = 1'b0; asa = 1'b0; ret = 1'b0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (s)
            S_FETCH:  begin mr = 1'b1; irw = 1'b1; pw = 1'b1; asb = 2'b01; end
            S_DECODE: asb = 2'b11;
            S_MADDR:  begin asa = 1'b1; asb = 2'b10; end
            S_MRD:    begin mr = 1'b1; iord = 1'b1; end
            S_MWB:    begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
            S_MWR:    begin mw = 1'b1; iord = 1'b1; ret = 1'b1; end
            S_EXEC:   begin asa = 1'b1; aop = 2'b10; end
            S_RWB:    begin rw = 1'b1; rd = 1'b1; ret = 1'b1; end
            S_BRANCH: begin asa = 1'b1; pwc = 1'b1; aop = 2'b01; pcs = 2'b01; ret = 1'b1; end
            S_JUMP:   begin pw = 1'b1; pcs = 2'b10; ret = 1'b1; end
            S_IEXEC:  begin asa = 1'b1; asb = 2'b10; end
            S_IWB:    begin rw = 1'b1; ret = 1'b1; end
            default:  ;
        endcase
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ret};
    endfunction

    // State register with controls registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RST;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= next_state(state_reg, opcode);
            ctrl_reg  <= decode_ctrl(next_state(state_reg, opcode));
        end
    end

    assign {PC_WRITE, PC_WRITE_COND, IorD, MEM_READ, MEM_WRITE, IR_WRITE, MEM_TO_REG,
            REG_DST, REG_WRITE, ALU_SRC_A, ALU_SRC_B, PC_SOURCE, ALU_OP, RETIRE} = ctrl_reg;

    assign STATE   = state_reg;
    assign PC_EN   = PC_WRITE | (PC_WRITE_COND & zero);
    assign ILLEGAL = (state_reg == S_DECODE) && !is_legal(opcode);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: directed scenarios plus a random
// back-to-back instruction stream checked against an instruction-level model.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       PC_WRITE, PC_WRITE_COND, IorD, MEM_READ, MEM_WRITE, IR_WRITE;
    logic       MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A;
    logic [1:0] ALU_SRC_B, PC_SOURCE, ALU_OP;
    logic       PC_EN, RETIRE, ILLEGAL;
    logic [3:0] STATE;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, pcs, aop;
        logic       pcen, ret, ill;
    } snap_t;

    snap_t tr[8];

    mc_main_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .PC_WRITE(PC_WRITE), .PC_WRITE_COND(PC_WRITE_COND), .IorD(IorD),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE),
        .MEM_TO_REG(MEM_TO_REG), .REG_DST(REG_DST), .REG_WRITE(REG_WRITE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .PC_SOURCE(PC_SOURCE),
        .ALU_OP(ALU_OP), .PC_EN(PC_EN), .RETIRE(RETIRE), .ILLEGAL(ILLEGAL),
        .STATE(STATE)
    );

    always #5 clk = ~clk;

    function automatic snap_t grab();
        return {STATE, PC_WRITE, PC_WRITE_COND, IorD, MEM_READ, MEM_WRITE, IR_WRITE,
                MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, ALU_SRC_B, PC_SOURCE, ALU_OP,
                PC_EN, RETIRE, ILLEGAL};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    // Cycles from FETCH through the retire state (or through DECODE if illegal).
    function automatic int path_len(input logic [5:0] op);
        case (op)
            6'h23: return 5;
            6'h2B, 6'h00, 6'h08: return 4;
            6'h04, 6'h02: return 3;
            default: return 2;
        endcase
    endfunction

    // State visited at cycle i of an instruction.
    function automatic int path_at(input logic [5:0] op, input int i);
        if (i == 0) return 0;
        if (i == 1) return 1;
        case (op)
            6'h23: return (i == 2) ? 2 : (i == 3) ? 3 : 4;
            6'h2B: return (i == 2) ? 2 : 5;
            6'h00: return (i == 2) ? 6 : 7;
            6'h08: return (i == 2) ? 10 : 11;
            6'h04: return 8;
            default: return 9;
        endcase
    endfunction

    function automatic snap_t exp_snap(input int s, input logic [5:0] op, input logic z);
        snap_t e;
        e = '0;
        e.st = 4'(s);
        case (s)
            0:  begin e.mr = 1; e.irw = 1; e.pw = 1; e.asb = 2'b01; end
            1:  begin e.asb = 2'b11; e.ill = !legal(op); end
            2:  begin e.asa = 1; e.asb = 2'b10; end
            3:  begin e.mr = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 1; e.ret = 1; end
            5:  begin e.mw = 1; e.iord = 1; e.ret = 1; end
            6:  begin e.asa = 1; e.aop = 2'b10; end
            7:  begin e.rw = 1; e.rd = 1; e.ret = 1; end
            8:  begin e.asa = 1; e.pwc = 1; e.aop = 2'b01; e.pcs = 2'b01; e.ret = 1; end
            9:  begin e.pw = 1; e.pcs = 2'b10; e.ret = 1; end
            10: begin e.asa = 1; e.asb = 2'b10; end
            11: begin e.rw = 1; e.ret = 1; end
            default: ;
        endcase
        e.pcen = e.pw | (e.pwc & z);
        return e;
    endfunction

    // Capture n cycles of one instruction starting in FETCH; leaves the bench at
    // the sample point of the following cycle.
    task automatic run_instr(input logic [5:0] op, input logic z, input int n);
        opcode = op;
        zero   = z;
        for (int i = 0; i < n; i++) begin
            tr[i] = grab();
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        zero  = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (grab() !== exp_snap(15, opcode, zero)) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, grab(), exp_snap(15, opcode, zero));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (STATE !== 4'd0 || MEM_READ !== 1 || IR_WRITE !== 1 || PC_WRITE !== 1 || ALU_SRC_B !== 2'b01) begin
            errors++;
            $display("FAIL reset_release state=%0d mr=%b irw=%b pw=%b asb=%b want 0/1/1/1/01",
                     STATE, MEM_READ, IR_WRITE, PC_WRITE, ALU_SRC_B);
        end
        $display("test_reset done state=%0d", STATE);
    endtask

    task automatic test_lw_sw();
        int exp_lw[5];
        int exp_sw[4];
        exp_lw = '{0, 1, 2, 3, 4};
        exp_sw = '{0, 1, 2, 5};
        run_instr(6'h23, 1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tr[i].st !== 4'(exp_lw[i]) || tr[i].ret !== (i == 4)) begin
                errors++;
                $display("FAIL lw_seq cyc=%0d state=%0d ret=%b want %0d/%b", i, tr[i].st, tr[i].ret, exp_lw[i], i == 4);
            end
        end
        checks++;
        if (tr[4].m2r !== 1'b1) begin
            errors++;
            $display("FAIL lw_mem_to_reg got=%b want=1", tr[4].m2r);
        end
        $display("lw  opcode=23 retired state=%0d", tr[4].st);
        run_instr(6'h2B, 1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tr[i].st !== 4'(exp_sw[i])) begin
                errors++;
                $display("FAIL sw_seq cyc=%0d state=%0d want %0d", i, tr[i].st, exp_sw[i]);
            end
        end
        checks++;
        if (tr[3].mw !== 1'b1 || tr[3].ret !== 1'b1) begin
            errors++;
            $display("FAIL sw_mem_write mw=%b ret=%b want 1/1", tr[3].mw, tr[3].ret);
        end
        $display("sw  opcode=2b retired state=%0d", tr[3].st);
    endtask

    task automatic test_rtype_addi();
        run_instr(6'h00, 1'b0, 4);
        checks++;
        if (tr[2].st !== 4'd6 || tr[2].aop !== 2'b10 || tr[3].st !== 4'd7 || tr[3].rd !== 1'b1) begin
            errors++;
            $display("FAIL rtype st=%0d aop=%b st=%0d rd=%b want 6/10/7/1", tr[2].st, tr[2].aop, tr[3].st, tr[3].rd);
        end
        $display("rtype opcode=00 exec aop=%b", tr[2].aop);
        run_instr(6'h08, 1'b0, 4);
        checks++;
        if (tr[2].st !== 4'd10 || tr[2].asb !== 2'b10 || tr[2].aop !== 2'b00 ||
            tr[3].st !== 4'd11 || tr[3].rd !== 1'b0 || tr[3].rw !== 1'b1) begin
            errors++;
            $display("FAIL addi st=%0d asb=%b aop=%b st=%0d rd=%b rw=%b want 10/10/00/11/0/1",
                     tr[2].st, tr[2].asb, tr[2].aop, tr[3].st, tr[3].rd, tr[3].rw);
        end
        $display("addi opcode=08 iexec asb=%b", tr[2].asb);
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            run_instr(6'h04, 1'(z), 3);
            checks++;
            if (tr[2].st !== 4'd8 || tr[2].pcen !== 1'(z) || tr[2].aop !== 2'b01 ||
                tr[2].pcs !== 2'b01 || tr[2].ret !== 1'b1 || STATE !== 4'd0) begin
                errors++;
                $display("FAIL beq_z%0d st=%0d pcen=%b aop=%b pcs=%b ret=%b next=%0d want 8/%0d/01/01/1/0",
                         z, tr[2].st, tr[2].pcen, tr[2].aop, tr[2].pcs, tr[2].ret, STATE, z);
            end
            $display("beq opcode=04 zero=%0d pc_en=%b", z, tr[2].pcen);
        end
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 1'b0, 2);
        checks++;
        if (tr[0].ill !== 1'b0 || tr[1].st !== 4'd1 || tr[1].ill !== 1'b1 || STATE !== 4'd0 || ILLEGAL !== 1'b0) begin
            errors++;
            $display("FAIL illegal ill0=%b st=%0d ill=%b next=%0d ill_next=%b want 0/1/1/0/0",
                     tr[0].ill, tr[1].st, tr[1].ill, STATE, ILLEGAL);
        end
        checks++;
        if ((tr[0].ret | tr[1].ret | tr[0].rw | tr[1].rw | tr[0].mw | tr[1].mw) !== 1'b0) begin
            errors++;
            $display("FAIL illegal_side_effects ret/rw/mw seen=1 want 0");
        end
        $display("illegal opcode=3f ill=%b", tr[1].ill);
    endtask

    task automatic test_mid_reset();
        logic bad;
        run_instr(6'h23, 1'b0, 3);
        checks++;
        if (STATE !== 4'd3) begin
            errors++;
            $display("FAIL midrst_reach state=%0d want 3", STATE);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (STATE !== 4'd15 || RETIRE !== 1'b0 || REG_WRITE !== 1'b0 || MEM_READ !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async state=%0d ret=%b rw=%b mr=%b want 15/0/0/0", STATE, RETIRE, REG_WRITE, MEM_READ);
        end
        bad = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bad |= RETIRE | REG_WRITE | (STATE != 4'd15);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold ret/rw/state-change seen=%b want 0", bad);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (STATE !== 4'd0 || IR_WRITE !== 1'b1) begin
            errors++;
            $display("FAIL midrst_restart state=%0d irw=%b want 0/1", STATE, IR_WRITE);
        end
        $display("mid-op reset restart state=%0d", STATE);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[6];
        logic [5:0] op;
        logic       z;
        int         n;
        snap_t      e;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
        for (int k = 0; k < 40; k++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            z  = 1'($urandom);
            n  = path_len(op);
            run_instr(op, z, n);
            for (int i = 0; i < n; i++) begin
                e = exp_snap(path_at(op, i), op, z);
                checks++;
                if (tr[i] !== e) begin
                    errors++;
                    $display("FAIL b2b k=%0d op=%h cyc=%0d got=%h want=%h", k, op, i, tr[i], e);
                end
                checks++;
                if ((tr[i].mr & tr[i].mw) !== 1'b0 || (tr[i].rw & tr[i].mw) !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_exclusive k=%0d cyc=%0d mr=%b mw=%b rw=%b want no overlap",
                             k, i, tr[i].mr, tr[i].mw, tr[i].rw);
                end
            end
            $display("b2b k=%0d op=%h zero=%0d cycles=%0d last_state=%0d", k, op, z, n, tr[n-1].st);
        end
        checks++;
        if (STATE !== 4'd0) begin
            errors++;
            $display("FAIL b2b_final state=%0d want 0", STATE);
        end
    endtask

    initial begin
        test_reset();
        test_lw_sw();
        test_rtype_addi();
        test_beq();
        test_illegal();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout state=%0d", STATE);
        $fatal(1, "timeout");
    end

endmodule
